// File: rtl/vend_controller.sv
// Vending transaction sequencer: credit accumulation, purchase check, dispense/change handshakes, operator table access.
// Optional idle auto-refund in COLLECT is enabled by defining VEND_TIMEOUT_EN.
module vend_controller #(
    parameter int          NUM_ITEMS     = 4,
    parameter logic [3:0]  DEFAULT_PRICE = 4'd2,
    parameter int          TIMEOUT       = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_coin_valid,
    input  logic [3:0]  i_coin_value,
    input  logic        i_sel_valid,
    input  logic [1:0]  i_sel_item,
    input  logic [3:0]  i_sel_qty,
    input  logic        i_cancel,
    input  logic        i_dispense_ack,
    input  logic        i_admin_req,
    input  logic        i_restock_valid,
    input  logic        i_price_wr,
    input  logic [1:0]  i_adm_item,
    input  logic [3:0]  i_adm_value,
    output logic        o_dispense_valid,
    output logic [1:0]  o_dispense_item,
    output logic [3:0]  o_dispense_qty,
    output logic        o_change_valid,
    output logic [3:0]  o_change_amount,
    output logic        o_coin_reject,
    output logic        o_redlight,
    output logic [3:0]  o_credit,
    output logic [10:0] o_machine_money,
    output logic        o_admin_active
);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHECK, S_DISPENSE, S_REFUND, S_ADMIN
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("vend_controller: TIMEOUT out of range 1..65535");
    end

    state_t      r_state;
    logic [3:0]  r_credit;
    logic [10:0] r_money;
    logic [3:0]  r_supply [NUM_ITEMS];
    logic [3:0]  r_price  [NUM_ITEMS];
    logic [1:0]  r_sel_item;
    logic [3:0]  r_sel_qty;
    logic        r_dispense_valid;
    logic        r_change_valid;
    logic [3:0]  r_change_amount;
    logic        r_coin_reject;
    logic        r_redlight;
    logic        r_admin_active;
`ifdef VEND_TIMEOUT_EN
    logic [15:0] r_timer;
`endif

    logic [7:0]  w_cost;
    logic        w_pass;
    logic [11:0] w_money_sum;
    logic [4:0]  w_coin_sum;
    logic [4:0]  w_restock_sum;

    always_comb begin
        w_cost        = {4'b0, r_price[r_sel_item]} * {4'b0, r_sel_qty};
        w_pass        = (r_sel_qty != 4'd0) && ({4'b0, r_credit} >= w_cost)
                        && (r_supply[r_sel_item] >= r_sel_qty);
        w_money_sum   = {1'b0, r_money} + {4'b0, w_cost};
        w_coin_sum    = {1'b0, r_credit} + {1'b0, i_coin_value};
        w_restock_sum = {1'b0, r_supply[i_adm_item]} + {1'b0, i_adm_value};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_credit         <= 4'd0;
            r_money          <= 11'd0;
            r_sel_item       <= 2'd0;
            r_sel_qty        <= 4'd0;
            r_dispense_valid <= 1'b0;
            r_change_valid   <= 1'b0;
            r_change_amount  <= 4'd0;
            r_coin_reject    <= 1'b0;
            r_redlight       <= 1'b0;
            r_admin_active   <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                r_supply[i] <= 4'd0;
                r_price[i]  <= DEFAULT_PRICE;
            end
`ifdef VEND_TIMEOUT_EN
            r_timer          <= 16'd0;
`endif
        end else begin
            // Any coin not explicitly accepted below is bounced next cycle.
            r_coin_reject  <= i_coin_valid;
            r_change_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_admin_req) begin
                        r_admin_active <= 1'b1;
                        r_state        <= S_ADMIN;
                    end else if (i_coin_valid) begin
                        r_credit      <= i_coin_value;
                        r_coin_reject <= 1'b0;
                        r_state       <= S_COLLECT;
`ifdef VEND_TIMEOUT_EN
                        r_timer       <= 16'd0;
`endif
                    end
                end
                S_COLLECT: begin
                    if (i_cancel) begin
                        r_change_valid  <= 1'b1;
                        r_change_amount <= r_credit;
                        r_state         <= S_REFUND;
                    end else if (i_sel_valid) begin
                        r_sel_item <= i_sel_item;
                        r_sel_qty  <= i_sel_qty;
                        r_state    <= S_CHECK;
                    end else if (i_coin_valid) begin
                        if (w_coin_sum <= 5'd15) begin
                            r_credit      <= w_coin_sum[3:0];
                            r_coin_reject <= 1'b0;
                        end
`ifdef VEND_TIMEOUT_EN
                        r_timer <= 16'd0;
`endif
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_change_valid  <= 1'b1;
                        r_change_amount <= r_credit;
                        r_state         <= S_REFUND;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
`endif
                end
                S_CHECK: begin
                    if (w_pass) begin
                        r_supply[r_sel_item] <= r_supply[r_sel_item] - r_sel_qty;
                        r_credit             <= r_credit - w_cost[3:0];
                        r_money              <= (w_money_sum > 12'd2047) ? 11'd2047 : w_money_sum[10:0];
                        r_redlight           <= 1'b0;
                        r_dispense_valid     <= 1'b1;
                        r_state              <= S_DISPENSE;
                    end else begin
                        r_redlight <= 1'b1;
                        r_state    <= S_COLLECT;
`ifdef VEND_TIMEOUT_EN
                        r_timer    <= 16'd0;
`endif
                    end
                end
                S_DISPENSE: begin
                    if (i_dispense_ack) begin
                        r_dispense_valid <= 1'b0;
                        r_change_valid   <= 1'b1;
                        r_change_amount  <= r_credit;
                        r_state          <= S_REFUND;
                    end
                end
                S_REFUND: begin
                    r_credit <= 4'd0;
                    r_state  <= S_IDLE;
                end
                S_ADMIN: begin
                    if (i_restock_valid)
                        r_supply[i_adm_item] <= (w_restock_sum > 5'd15) ? 4'd15 : w_restock_sum[3:0];
                    if (i_price_wr)
                        r_price[i_adm_item] <= i_adm_value;
                    if (!i_admin_req) begin
                        r_admin_active <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dispense_valid = r_dispense_valid;
    assign o_dispense_item  = r_sel_item;
    assign o_dispense_qty   = r_sel_qty;
    assign o_change_valid   = r_change_valid;
    assign o_change_amount  = r_change_amount;
    assign o_coin_reject    = r_coin_reject;
    assign o_redlight       = r_redlight;
    assign o_credit         = r_credit;
    assign o_machine_money  = r_money;
    assign o_admin_active   = r_admin_active;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: purchase flow, coin limits, failed checks, admin tables, reset and idle timeout.
module tb_vend_controller;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_coin_valid = 1'b0;
    logic [3:0]  i_coin_value = 4'd0;
    logic        i_sel_valid = 1'b0;
    logic [1:0]  i_sel_item = 2'd0;
    logic [3:0]  i_sel_qty = 4'd0;
    logic        i_cancel = 1'b0;
    logic        i_dispense_ack = 1'b0;
    logic        i_admin_req = 1'b0;
    logic        i_restock_valid = 1'b0;
    logic        i_price_wr = 1'b0;
    logic [1:0]  i_adm_item = 2'd0;
    logic [3:0]  i_adm_value = 4'd0;
    logic        o_dispense_valid;
    logic [1:0]  o_dispense_item;
    logic [3:0]  o_dispense_qty;
    logic        o_change_valid;
    logic [3:0]  o_change_amount;
    logic        o_coin_reject;
    logic        o_redlight;
    logic [3:0]  o_credit;
    logic [10:0] o_machine_money;
    logic        o_admin_active;

    int checks = 0;
    int failures = 0;

    vend_controller #(.NUM_ITEMS(4), .DEFAULT_PRICE(4'd2), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_coin_valid(i_coin_valid), .i_coin_value(i_coin_value),
        .i_sel_valid(i_sel_valid), .i_sel_item(i_sel_item), .i_sel_qty(i_sel_qty),
        .i_cancel(i_cancel), .i_dispense_ack(i_dispense_ack), .i_admin_req(i_admin_req),
        .i_restock_valid(i_restock_valid), .i_price_wr(i_price_wr),
        .i_adm_item(i_adm_item), .i_adm_value(i_adm_value),
        .o_dispense_valid(o_dispense_valid), .o_dispense_item(o_dispense_item),
        .o_dispense_qty(o_dispense_qty), .o_change_valid(o_change_valid),
        .o_change_amount(o_change_amount), .o_coin_reject(o_coin_reject),
        .o_redlight(o_redlight), .o_credit(o_credit),
        .o_machine_money(o_machine_money), .o_admin_active(o_admin_active)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic put_coin(input logic [3:0] v);
        i_coin_valid = 1'b1; i_coin_value = v;
        step();
        i_coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] item, input logic [3:0] qty);
        i_sel_valid = 1'b1; i_sel_item = item; i_sel_qty = qty;
        step();
        i_sel_valid = 1'b0;
    endtask

    task automatic ack();
        i_dispense_ack = 1'b1;
        step();
        i_dispense_ack = 1'b0;
    endtask

    task automatic cancel();
        i_cancel = 1'b1;
        step();
        i_cancel = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        step(); step();
        checks++; if (o_dispense_valid !== 1'b0) begin failures++; $display("FAIL rst_dv got=%0b exp=0", o_dispense_valid); end
        checks++; if (o_change_valid !== 1'b0) begin failures++; $display("FAIL rst_cv got=%0b exp=0", o_change_valid); end
        checks++; if (o_credit !== 4'd0) begin failures++; $display("FAIL rst_credit got=%0d exp=0", o_credit); end
        checks++; if (o_machine_money !== 11'd0) begin failures++; $display("FAIL rst_money got=%0d exp=0", o_machine_money); end
        checks++; if ({o_redlight, o_coin_reject, o_admin_active} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {o_redlight, o_coin_reject, o_admin_active}); end
        i_rst_n = 1'b1;
        step();
        i_sel_valid = 1'b1; i_cancel = 1'b1;
        step();
        i_sel_valid = 1'b0; i_cancel = 1'b0;
        step();
        checks++; if ({o_dispense_valid, o_change_valid} !== 2'b00) begin failures++; $display("FAIL idle_ignore got=%b exp=00", {o_dispense_valid, o_change_valid}); end
    endtask

    task automatic test_admin_setup();
        i_admin_req = 1'b1; i_coin_valid = 1'b1; i_coin_value = 4'd3;
        step();
        i_coin_valid = 1'b0;
        checks++; if (o_admin_active !== 1'b1) begin failures++; $display("FAIL adm_enter got=%0b exp=1", o_admin_active); end
        checks++; if (o_coin_reject !== 1'b1) begin failures++; $display("FAIL adm_coin_rej got=%0b exp=1", o_coin_reject); end
        checks++; if (o_credit !== 4'd0) begin failures++; $display("FAIL adm_credit got=%0d exp=0", o_credit); end
        i_restock_valid = 1'b1; i_adm_item = 2'd0; i_adm_value = 4'd3;
        step();
        i_adm_item = 2'd2; i_adm_value = 4'd5;
        step();
        i_restock_valid = 1'b0; i_admin_req = 1'b0;
        step();
        checks++; if (o_admin_active !== 1'b0) begin failures++; $display("FAIL adm_exit got=%0b exp=0", o_admin_active); end
    endtask

    task automatic test_purchase();
        put_coin(4'd5);
        checks++; if (o_credit !== 4'd5) begin failures++; $display("FAIL buy_c1 got=%0d exp=5", o_credit); end
        put_coin(4'd5);
        checks++; if (o_credit !== 4'd10) begin failures++; $display("FAIL buy_c2 got=%0d exp=10", o_credit); end
        select(2'd0, 4'd2);
        checks++; if (o_dispense_valid !== 1'b0) begin failures++; $display("FAIL buy_dv_early got=%0b exp=0", o_dispense_valid); end
        step();
        checks++; if (o_dispense_valid !== 1'b1) begin failures++; $display("FAIL buy_dv got=%0b exp=1", o_dispense_valid); end
        checks++; if ({o_dispense_item, o_dispense_qty} !== {2'd0, 4'd2}) begin failures++; $display("FAIL buy_itemqty got=%0d/%0d exp=0/2", o_dispense_item, o_dispense_qty); end
        checks++; if (o_credit !== 4'd6) begin failures++; $display("FAIL buy_credit got=%0d exp=6", o_credit); end
        checks++; if (o_machine_money !== 11'd4) begin failures++; $display("FAIL buy_money got=%0d exp=4", o_machine_money); end
        checks++; if (o_redlight !== 1'b0) begin failures++; $display("FAIL buy_red got=%0b exp=0", o_redlight); end
        put_coin(4'd1);
        checks++; if ({o_coin_reject, o_credit} !== {1'b1, 4'd6}) begin failures++; $display("FAIL disp_coin got=%0b/%0d exp=1/6", o_coin_reject, o_credit); end
        step();
        checks++; if ({o_dispense_valid, o_dispense_qty} !== {1'b1, 4'd2}) begin failures++; $display("FAIL disp_hold got=%0b/%0d exp=1/2", o_dispense_valid, o_dispense_qty); end
        ack();
        checks++; if ({o_dispense_valid, o_change_valid} !== 2'b01) begin failures++; $display("FAIL ack_flags got=%b exp=01", {o_dispense_valid, o_change_valid}); end
        checks++; if (o_change_amount !== 4'd6) begin failures++; $display("FAIL ack_change got=%0d exp=6", o_change_amount); end
        step();
        checks++; if ({o_change_valid, o_credit} !== {1'b0, 4'd0}) begin failures++; $display("FAIL refund_done got=%0b/%0d exp=0/0", o_change_valid, o_credit); end
        // One unit of item0 remains: qty2 must fail on supply, qty1 must pass.
        put_coin(4'd5);
        select(2'd0, 4'd2);
        step();
        checks++; if ({o_redlight, o_dispense_valid} !== 2'b10) begin failures++; $display("FAIL supply_fail got=%b exp=10", {o_redlight, o_dispense_valid}); end
        checks++; if ({o_credit, o_machine_money} !== {4'd5, 11'd4}) begin failures++; $display("FAIL supply_keep got=%0d/%0d exp=5/4", o_credit, o_machine_money); end
        select(2'd0, 4'd1);
        step();
        checks++; if ({o_dispense_valid, o_redlight, o_credit} !== {1'b1, 1'b0, 4'd3}) begin failures++; $display("FAIL last_unit got=%b/%0d exp=10/3", {o_dispense_valid, o_redlight}, o_credit); end
        checks++; if (o_machine_money !== 11'd6) begin failures++; $display("FAIL last_money got=%0d exp=6", o_machine_money); end
        ack();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd3}) begin failures++; $display("FAIL last_change got=%0b/%0d exp=1/3", o_change_valid, o_change_amount); end
        step();
    endtask

    task automatic test_coin_overflow();
        put_coin(4'd12);
        checks++; if (o_credit !== 4'd12) begin failures++; $display("FAIL ovf_c12 got=%0d exp=12", o_credit); end
        put_coin(4'd4);
        checks++; if ({o_coin_reject, o_credit} !== {1'b1, 4'd12}) begin failures++; $display("FAIL ovf_rej got=%0b/%0d exp=1/12", o_coin_reject, o_credit); end
        put_coin(4'd3);
        checks++; if ({o_coin_reject, o_credit} !== {1'b0, 4'd15}) begin failures++; $display("FAIL ovf_15 got=%0b/%0d exp=0/15", o_coin_reject, o_credit); end
        cancel();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd15}) begin failures++; $display("FAIL ovf_cancel got=%0b/%0d exp=1/15", o_change_valid, o_change_amount); end
        step();
        checks++; if ({o_change_valid, o_credit} !== {1'b0, 4'd0}) begin failures++; $display("FAIL ovf_after got=%0b/%0d exp=0/0", o_change_valid, o_credit); end
    endtask

    task automatic test_fail_check();
        put_coin(4'd3);
        select(2'd2, 4'd2);
        step();
        checks++; if ({o_redlight, o_dispense_valid, o_credit} !== {1'b1, 1'b0, 4'd3}) begin failures++; $display("FAIL poor_check got=%b/%0d exp=10/3", {o_redlight, o_dispense_valid}, o_credit); end
        checks++; if (o_machine_money !== 11'd6) begin failures++; $display("FAIL poor_money got=%0d exp=6", o_machine_money); end
        cancel();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd3}) begin failures++; $display("FAIL poor_cancel got=%0b/%0d exp=1/3", o_change_valid, o_change_amount); end
        step();
        put_coin(4'd4);
        select(2'd2, 4'd2);
        step();
        checks++; if ({o_dispense_valid, o_redlight, o_credit} !== {1'b1, 1'b0, 4'd0}) begin failures++; $display("FAIL exact_buy got=%b/%0d exp=10/0", {o_dispense_valid, o_redlight}, o_credit); end
        checks++; if (o_machine_money !== 11'd10) begin failures++; $display("FAIL exact_money got=%0d exp=10", o_machine_money); end
        ack();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd0}) begin failures++; $display("FAIL zero_change got=%0b/%0d exp=1/0", o_change_valid, o_change_amount); end
        step();
        put_coin(4'd2);
        i_sel_valid = 1'b1; i_sel_item = 2'd2; i_sel_qty = 4'd0;
        i_coin_valid = 1'b1; i_coin_value = 4'd1;
        step();
        i_sel_valid = 1'b0; i_coin_valid = 1'b0;
        checks++; if ({o_coin_reject, o_credit} !== {1'b1, 4'd2}) begin failures++; $display("FAIL sel_coin got=%0b/%0d exp=1/2", o_coin_reject, o_credit); end
        step();
        checks++; if ({o_redlight, o_dispense_valid, o_credit} !== {1'b1, 1'b0, 4'd2}) begin failures++; $display("FAIL qty0 got=%b/%0d exp=10/2", {o_redlight, o_dispense_valid}, o_credit); end
        cancel();
        checks++; if (o_change_amount !== 4'd2) begin failures++; $display("FAIL qty0_cancel got=%0d exp=2", o_change_amount); end
        step();
    endtask

    task automatic test_admin_tables();
        i_admin_req = 1'b1;
        step();
        i_restock_valid = 1'b1; i_adm_item = 2'd1; i_adm_value = 4'd10;
        step(); step();
        i_restock_valid = 1'b0; i_price_wr = 1'b1; i_adm_value = 4'd1;
        step();
        i_price_wr = 1'b0; i_admin_req = 1'b0;
        step();
        // Price 1 x qty 15 only passes if supply saturated at 15 rather than wrapping.
        put_coin(4'd15);
        select(2'd1, 4'd15);
        step();
        checks++; if ({o_dispense_valid, o_dispense_qty, o_credit} !== {1'b1, 4'd15, 4'd0}) begin failures++; $display("FAIL sat_buy got=%0b/%0d/%0d exp=1/15/0", o_dispense_valid, o_dispense_qty, o_credit); end
        checks++; if (o_machine_money !== 11'd25) begin failures++; $display("FAIL sat_money got=%0d exp=25", o_machine_money); end
        ack(); step();
        i_admin_req = 1'b1;
        step();
        i_restock_valid = 1'b1; i_price_wr = 1'b1; i_adm_item = 2'd1; i_adm_value = 4'd7;
        step();
        i_restock_valid = 1'b0; i_price_wr = 1'b0; i_admin_req = 1'b0;
        step();
        put_coin(4'd10);
        select(2'd1, 4'd1);
        step();
        checks++; if ({o_dispense_valid, o_dispense_item, o_credit} !== {1'b1, 2'd1, 4'd3}) begin failures++; $display("FAIL price7 got=%0b/%0d/%0d exp=1/1/3", o_dispense_valid, o_dispense_item, o_credit); end
        checks++; if (o_machine_money !== 11'd32) begin failures++; $display("FAIL price7_money got=%0d exp=32", o_machine_money); end
        ack();
        checks++; if (o_change_amount !== 4'd3) begin failures++; $display("FAIL price7_change got=%0d exp=3", o_change_amount); end
        step();
        put_coin(4'd1);
        i_admin_req = 1'b1;
        step();
        checks++; if (o_admin_active !== 1'b0) begin failures++; $display("FAIL adm_in_collect got=%0b exp=0", o_admin_active); end
        i_admin_req = 1'b0;
        cancel();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd1}) begin failures++; $display("FAIL adm_collect_cancel got=%0b/%0d exp=1/1", o_change_valid, o_change_amount); end
        step();
    endtask

    task automatic test_reset_mid_dispense();
        put_coin(4'd5);
        select(2'd2, 4'd1);
        step();
        checks++; if (o_dispense_valid !== 1'b1) begin failures++; $display("FAIL md_dv got=%0b exp=1", o_dispense_valid); end
        i_rst_n = 1'b0;
        step();
        checks++; if ({o_dispense_valid, o_change_valid, o_dispense_item, o_dispense_qty} !== 8'd0) begin failures++; $display("FAIL md_disp got=%0b/%0b/%0d/%0d exp=0/0/0/0", o_dispense_valid, o_change_valid, o_dispense_item, o_dispense_qty); end
        checks++; if ({o_credit, o_machine_money, o_change_amount} !== 19'd0) begin failures++; $display("FAIL md_regs got=%0d/%0d/%0d exp=0/0/0", o_credit, o_machine_money, o_change_amount); end
        i_rst_n = 1'b1;
        step();
        checks++; if ({o_change_valid, o_dispense_valid} !== 2'b00) begin failures++; $display("FAIL md_after got=%b exp=00", {o_change_valid, o_dispense_valid}); end
    endtask

`ifdef VEND_TIMEOUT_EN
    task automatic test_timeout();
        int seen_at = 0;
        logic [3:0] amt = 4'd0;
        put_coin(4'd4);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (o_change_valid && seen_at == 0) begin
                seen_at = k;
                amt = o_change_amount;
            end
        end
        checks++; if (seen_at != 8) begin failures++; $display("FAIL timeout_cycle got=%0d exp=8", seen_at); end
        checks++; if (amt !== 4'd4) begin failures++; $display("FAIL timeout_amount got=%0d exp=4", amt); end
    endtask
`else
    task automatic test_no_timeout();
        int seen = 0;
        put_coin(4'd4);
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_change_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL no_timeout got=%0d exp=0", seen); end
        cancel();
        checks++; if ({o_change_valid, o_change_amount} !== {1'b1, 4'd4}) begin failures++; $display("FAIL no_timeout_cancel got=%0b/%0d exp=1/4", o_change_valid, o_change_amount); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_admin_setup();
        test_purchase();
        test_coin_overflow();
        test_fail_check();
        test_admin_tables();
        test_reset_mid_dispense();
`ifdef VEND_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction sequencer for the vending machine. Accumulates customer credit from coin inserts and holds per-product price and supply tables. On a selection it runs the purchase check, debiting credit and supply and crediting machine money, then drives the dispense/change handshakes. It also grants exclusive access to the tables in operator (admin) mode. It sits between the front-panel/coin inputs and the dispenser, and it is the only writer of supply, price and machine-money state.

## Interface
- NUM_ITEMS, 4: product slots; item index width is 2.
- DEFAULT_PRICE, 4'd2: reset value of every price entry.
- TIMEOUT, 255: idle cycles in COLLECT before auto-refund. Range 1..65535.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset. Synchronous, active-low.
- coin_valid  in  1  one-cycle coin insert strobe.
- coin_value  in  4  value of the inserted coin.
- sel_valid  in  1  selection strobe.
- sel_item  in  2  selected product.
- sel_qty  in  4  requested quantity.
- cancel  in  1  customer cancel strobe.
- dispense_ack  in  1  dispenser accepted the current dispense.
- admin_req  in  1  level; operator mode request.
- restock_valid  in  1  admin restock strobe.
- price_wr  in  1  admin price-write strobe.
- adm_item  in  2  admin target slot.
- adm_value  in  4  restock quantity or new price.
- dispense_valid  out  1  dispense request; held until ack.
- dispense_item  out  2  product being dispensed.
- dispense_qty  out  4  quantity being dispensed.
- change_valid  out  1  one-cycle change strobe.
- change_amount  out  4  change returned.
- coin_reject  out  1  one-cycle pulse; coin not accepted.
- redlight  out  1  last purchase check failed.
- credit  out  4  current customer credit.
- machine_money  out  11  accumulated takings.
- admin_active  out  1  FSM is in ADMIN.

## Operation
- States: IDLE, COLLECT, CHECK, DISPENSE, REFUND, ADMIN. Reset state is IDLE.
- IDLE, credit is 0:
  - admin_req → ADMIN. A coin in the same cycle is rejected.
  - Otherwise coin_valid → credit = coin_value, go to COLLECT.
  - sel_valid and cancel are ignored.
- COLLECT, priority cancel > sel_valid > coin_valid:
  - cancel → REFUND.
  - sel_valid → latch sel_item/sel_qty, go to CHECK.
  - A coin arriving in the same cycle as cancel or sel_valid pulses coin_reject.
  - coin_valid alone: accept if credit+coin_value ≤ 15, else coin_reject and credit unchanged.
  - admin_req is ignored outside IDLE.
- CHECK, one cycle. cost = price[item]*qty, computed at 8 bits; credit is zero-extended for the compare. The check passes when qty≠0, credit ≥ cost, and supply[item] ≥ qty.
  - Pass: supply[item] -= qty; credit -= cost; machine_money += cost, saturating at 2047; redlight ← 0; go to DISPENSE.
  - Fail: redlight ← 1; nothing else changes; go back to COLLECT.
- DISPENSE: dispense_valid=1 with the latched item/qty held stable. dispense_ack → REFUND. Coins, cancel and sel are rejected/ignored here.
- REFUND: change_valid=1 and change_amount=credit for one cycle. change_valid pulses even when credit is 0. credit ← 0, go to IDLE.
- ADMIN:
  - restock_valid: supply[adm_item] = min(15, supply+adm_value).
  - price_wr: price[adm_item] = adm_value.
  - If both strobes are asserted, both apply.
  - admin_req low → IDLE.
- Reset values: all outputs 0; supply table 0; price table DEFAULT_PRICE; machine_money 0; timeout counter 0.

## Timing
- Coin accepted at edge N: credit is visible after edge N.
- sel_valid at edge N: CHECK runs in cycle N+1. dispense_valid or redlight is updated after edge N+1.
- dispense_ack sampled high at edge M: dispense_valid drops after M. change_valid is high in cycle M+1 only.
- coin_reject is registered and pulses the cycle after the offending strobe.
- redlight holds its value until the next CHECK or reset.
- A reset in any state, including mid-DISPENSE, returns to IDLE next edge. Credit is discarded and no change is issued.

## Configuration
- VEND_TIMEOUT_EN defined: a 16-bit counter runs in COLLECT.
  - The counter clears on entry to COLLECT and on any coin_valid or sel_valid.
  - When the counter reaches TIMEOUT-1 with no such event, the FSM goes to REFUND.
- VEND_TIMEOUT_EN undefined: no counter. COLLECT is left only by cancel or sel_valid.

## Test plan
- Reset, insert coin 5, coin 5, then sel item0 qty2 with price 2 and supply 3 → dispense item0 qty2; ack → change_amount 6; supply0=1; machine_money=4; redlight 0.
- Credit 12, insert coin 4 → coin_reject pulse, credit stays 12.
- Credit 3, sel qty2 at price 2 → redlight=1, credit 3, supply and money unchanged, back in COLLECT. cancel → change_amount 3.
- ADMIN: restock item1 +10 twice → supply1=15. price_wr item1=7 → a later purchase of qty1 costs 7.
- With VEND_TIMEOUT_EN and TIMEOUT=8: coin 4, then idle → change_valid with amount 4 exactly 8 cycles after the coin.
- rst_n low while dispense_valid is held → IDLE with all outputs 0 and no change_valid.
